// File: rtl/ecp5pll_phase_ctrl.sv
// ecp5pll_phase_ctrl: sequences EHXPLLL dynamic phase steps and tracks per-channel phase position.
// Optional absolute-target mode is enabled by defining ECP5PLL_PHASE_ABS_EN.
module ecp5pll_phase_ctrl #(
  parameter int CHANNELS      = 4,
  parameter int STEP_W        = 8,
  parameter int STEPS_PER_REV = 64,
  parameter int POS_W         = $clog2(STEPS_PER_REV),
  parameter int SETUP_CYC     = 2,
  parameter int PULSE_CYC     = 2,
  parameter int GAP_CYC       = 4
) (
  input  logic                      clk_i,
  input  logic                      reset,
  input  logic                      locked,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_chan,
  input  logic                      req_dir,
  input  logic [STEP_W-1:0]         req_steps,
  output logic [1:0]                phasesel,
  output logic                      phasedir,
  output logic                      phasestep,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [CHANNELS*POS_W-1:0] pos_o
);
  typedef enum logic [2:0] {IDLE, SETUP, STEP_HI, STEP_LO, DONE} state_t;
  localparam logic [POS_W-1:0] MAXP = POS_W'(STEPS_PER_REV - 1);
  state_t state;
  logic [7:0] cnt;
  logic [STEP_W-1:0] rem;
  logic [1:0] chan_q;
  logic [POS_W-1:0] pos [CHANNELS];
  logic [POS_W-1:0] cur_pos, sel_pos, nxt_pos;
  logic a_dir, a_bad, enter_hi, accept;
  logic [STEP_W-1:0] a_n;
  always_comb begin
    cur_pos = '0;
    sel_pos = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (req_chan == 2'(i)) cur_pos = pos[i];
      if (chan_q == 2'(i)) sel_pos = pos[i];
    end
    nxt_pos = phasedir ? (sel_pos == '0 ? MAXP : sel_pos - POS_W'(1))
                       : (sel_pos == MAXP ? '0 : sel_pos + POS_W'(1));
  end
`ifdef ECP5PLL_PHASE_ABS_EN
  logic [POS_W:0] sum, delta;
  logic unused_dir;
  assign unused_dir = req_dir;
  // Shortest way round the circle; ties at half a revolution go forward.
  always_comb begin
    sum   = {1'b0, req_steps[POS_W-1:0]} + (POS_W+1)'(STEPS_PER_REV) - {1'b0, cur_pos};
    delta = sum >= (POS_W+1)'(STEPS_PER_REV) ? sum - (POS_W+1)'(STEPS_PER_REV) : sum;
    a_dir = delta > (POS_W+1)'(STEPS_PER_REV / 2);
    a_n   = a_dir ? STEP_W'((POS_W+1)'(STEPS_PER_REV) - delta) : STEP_W'(delta);
    a_bad = int'(req_chan) >= CHANNELS || int'(req_steps) >= STEPS_PER_REV;
  end
`else
  logic [POS_W-1:0] unused_pos;
  assign unused_pos = cur_pos;
  assign a_dir = req_dir;
  assign a_n   = req_steps;
  assign a_bad = int'(req_chan) >= CHANNELS;
`endif
  assign req_ready = (state == IDLE) & locked & ~reset;
  assign accept    = req_valid & req_ready;
  assign busy      = state != IDLE;
  assign enter_hi  = locked & ((state == SETUP && cnt == 8'(SETUP_CYC - 1)) |
                               (state == STEP_LO && cnt == 8'(GAP_CYC - 1) && rem != '0));
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      chan_q    <= '0;
      phasesel  <= '0;
      phasedir  <= 1'b0;
      phasestep <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) pos[i] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      cnt  <= cnt + 8'd1;
      if (enter_hi) begin
        state     <= STEP_HI;
        phasestep <= 1'b1;
        cnt       <= '0;
        rem       <= rem - STEP_W'(1);
        for (int i = 0; i < CHANNELS; i++) if (chan_q == 2'(i)) pos[i] <= nxt_pos;
      end else begin
        case (state)
          IDLE: if (accept) begin
            chan_q   <= req_chan;
            phasesel <= req_chan;
            phasedir <= a_dir;
            rem      <= a_n;
            cnt      <= '0;
            state    <= (a_bad || a_n == '0) ? DONE : SETUP;
            done     <= a_bad || a_n == '0;
            err      <= a_bad;
          end
          DONE: state <= IDLE;
          default: if (!locked || (state == STEP_LO && cnt == 8'(GAP_CYC - 1))) begin
            state     <= DONE;
            done      <= 1'b1;
            err       <= !locked;
            phasestep <= 1'b0;
          end else if (state == STEP_HI && cnt == 8'(PULSE_CYC - 1)) begin
            state     <= STEP_LO;
            phasestep <= 1'b0;
            cnt       <= '0;
          end
        endcase
      end
    end
  end
  for (genvar g = 0; g < CHANNELS; g++) begin : g_pos
    assign pos_o[g*POS_W +: POS_W] = pos[g];
  end
endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// tb_ecp5pll_phase_ctrl: directed stimulus with a cycle-offset reference model checked every cycle.
module tb_ecp5pll_phase_ctrl;
  localparam int CH = 3, SU = 2, P = 2, G = 4, SPR = 64, PW = 6;
  logic clk = 1'b0, reset, locked = 1'b1, req_valid = 1'b0, req_ready, req_dir = 1'b0;
  logic [1:0] req_chan = '0, phasesel;
  logic [7:0] req_steps = '0;
  logic phasedir, phasestep, busy, done, err;
  logic [CH*PW-1:0] pos_o;
  int errors = 0, checks = 0;

  ecp5pll_phase_ctrl #(.CHANNELS(CH), .STEP_W(8), .STEPS_PER_REV(SPR), .SETUP_CYC(SU),
                       .PULSE_CYC(P), .GAP_CYC(G)) dut (
    .clk_i(clk), .reset(reset), .locked(locked), .req_valid(req_valid), .req_ready(req_ready),
    .req_chan(req_chan), .req_dir(req_dir), .req_steps(req_steps), .phasesel(phasesel),
    .phasedir(phasedir), .phasestep(phasestep), .busy(busy), .done(done), .err(err), .pos_o(pos_o));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: k counts cycles since acceptance, L is the cycle in which done is due.
  bit m_active = 0, m_err = 0, m_dir = 0;
  int k = 0, L = 0, m_chan = 0;
  logic [1:0] m_sel = '0;
  int m_pos [CH] = '{default: 0};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 0; m_err = 0; m_dir = 0; m_sel = '0; k = 0; L = 0;
      foreach (m_pos[i]) m_pos[i] = 0;
    end else if (m_active) begin
      if (k == L) m_active = 0;
      else if (!locked) begin k++; L = k; m_err = 1; end
      else begin
        k++;
        if (k < L && k > SU && (k - SU - 1) % (P + G) == 0)
          m_pos[m_chan] = m_dir ? (m_pos[m_chan] + SPR - 1) % SPR : (m_pos[m_chan] + 1) % SPR;
      end
    end else if (req_valid && locked) begin
      int n, t, delta;
      bit bad;
      m_chan = int'(req_chan);
      m_sel = req_chan;
      bad = m_chan >= CH;
`ifdef ECP5PLL_PHASE_ABS_EN
      t = int'(req_steps);
      bad = bad || t >= SPR;
      delta = bad ? 0 : ((t - m_pos[m_chan]) % SPR + SPR) % SPR;
      m_dir = delta > SPR / 2;
      n = m_dir ? SPR - delta : delta;
`else
      m_dir = req_dir;
      n = int'(req_steps);
`endif
      m_err = bad;
      k = 1;
      L = (bad || n == 0) ? 1 : SU + n * (P + G) + 1;
      m_active = 1;
    end
  end

  always @(negedge clk) begin
    bit e_done;
    e_done = m_active && k == L;
    chk("req_ready", req_ready, int'(!m_active && locked && !reset));
    chk("busy", busy, m_active);
    chk("done", done, e_done);
    if (e_done) chk("err", err, m_err);
    chk("phasestep", phasestep, int'(m_active && k < L && k > SU && (k - SU - 1) % (P + G) < P));
    chk("phasesel", phasesel, m_sel);
    chk("phasedir", phasedir, m_dir);
    chk("pos_o", int'(pos_o), int'({PW'(m_pos[2]), PW'(m_pos[1]), PW'(m_pos[0])}));
  end

  task automatic send(input int ch, input bit d, input int s);
    bit ok = 0;
    @(posedge clk); #1;
    req_chan = 2'(ch); req_dir = d; req_steps = 8'(s); req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) chk("ready_timeout", 0, 1);
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int pulses, output int e);
    bit prev = 0;
    lat = 0; pulses = 0; e = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      lat++;
      if (phasestep && !prev) pulses++;
      prev = phasestep;
      if (done) begin e = int'(err); return; end
    end
    chk("done_timeout", 0, 1);
  endtask

  initial begin
    int lat, np, e;
    bit seen;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_step", phasestep, 0);
    chk("rst_pos", int'(pos_o), 0);
    chk("rst_sel", phasesel, 0);
    reset = 1'b0;
`ifdef ECP5PLL_PHASE_ABS_EN
    send(0, 0, 10); wait_done(lat, np, e);
    chk("abs10_lat", lat, 63); chk("abs10_pos", int'(pos_o[5:0]), 10);
    send(0, 0, 50); wait_done(lat, np, e);
    chk("abs50_pulses", np, 24); chk("abs50_dir", phasedir, 1); chk("abs50_pos", int'(pos_o[5:0]), 50);
    send(0, 0, 10); wait_done(lat, np, e);
    chk("abs_back_pulses", np, 24); chk("abs_back_dir", phasedir, 0);
    send(0, 0, 20); wait_done(lat, np, e);
    chk("abs20_pulses", np, 10); chk("abs20_dir", phasedir, 0); chk("abs20_pos", int'(pos_o[5:0]), 20);
    send(0, 0, 64); wait_done(lat, np, e);
    chk("abs64_lat", lat, 1); chk("abs64_err", e, 1); chk("abs64_pulses", np, 0);
    send(0, 0, 20); wait_done(lat, np, e);
    chk("abs_same_lat", lat, 1); chk("abs_same_err", e, 0);
`else
    send(1, 0, 3); wait_done(lat, np, e);
    chk("t1_lat", lat, 21); chk("t1_pulses", np, 3); chk("t1_err", e, 0);
    chk("t1_pos1", int'(pos_o[11:6]), 3);
    send(2, 1, 2); wait_done(lat, np, e);
    chk("t2_lat", lat, 15); chk("t2_pos_dn", int'(pos_o[17:12]), 62);
    send(2, 0, 5); wait_done(lat, np, e);
    chk("t2_pos_up", int'(pos_o[17:12]), 3);
    send(0, 0, 0); wait_done(lat, np, e);
    chk("n0_lat", lat, 1); chk("n0_err", e, 0); chk("n0_pulses", np, 0);
    send(3, 0, 4); wait_done(lat, np, e);
    chk("chan3_lat", lat, 1); chk("chan3_err", e, 1); chk("chan3_pulses", np, 0);
    // request held while unlocked
    @(posedge clk); #1;
    locked = 1'b0; req_chan = 2'd0; req_dir = 1'b0; req_steps = 8'd1; req_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("unlk_ready", req_ready, 0); chk("unlk_busy", busy, 0);
    end
    @(posedge clk); #1 locked = 1'b1;
    @(negedge clk); chk("relock_ready", req_ready, 1);
    @(posedge clk); #1 req_valid = 1'b0;
    wait_done(lat, np, e);
    chk("relock_lat", lat, 9); chk("relock_pos0", int'(pos_o[5:0]), 1);
    // lock lost after the 4th pulse rises
    send(0, 0, 10);
    np = 0; seen = 0;
    for (int i = 0; i < 500 && np < 4; i++) begin
      @(negedge clk);
      if (phasestep && !seen) np++;
      seen = phasestep;
    end
    chk("abort_reach4", np, 4);
    locked = 1'b0;
    @(negedge clk);
    chk("abort_step", phasestep, 0); chk("abort_done", done, 1); chk("abort_err", err, 1);
    chk("abort_pos0", int'(pos_o[5:0]), 5);
    @(posedge clk); #1 locked = 1'b1;
`endif
    // reset during a pulse
    send(1, 0, 5);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = phasestep;
    end
    chk("pre_rst_pulse", seen, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_step", phasestep, 0); chk("arst_busy", busy, 0);
    chk("arst_done", done, 0); chk("arst_pos", int'(pos_o), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1); chk("post_rst_busy", busy, 0);
    @(posedge clk); #1 locked = 1'b0;
    @(negedge clk);
    chk("post_rst_unlk", req_ready, 0);
    @(posedge clk); #1 locked = 1'b1;
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
